rf_wb_sched: RTL and testbench
==============================

# rf_wb_sched

Write-port scheduler and scoreboard for the pipeline register file. It shares the RF's single write port between the in-order pipeline writeback stage and a long-latency unit (mul/div) that returns results out of band. It buffers long-unit results in a small FIFO and tracks registers with pending long-unit writes. It also tells the decode stage when to stall on RAW/WAW hazards or write-port starvation.

## Interface
- DEPTH, 2, long-unit result FIFO entries (power of two, ≥2)
- STARVE_MAX, 4, consecutive blocked cycles before a starvation stall is forced (≥1)
- clk  in  1  pipeline clock; FIFO, scoreboard and counter update on posedge
- rst  in  1  reset, asynchronous, active-high
- wb_we  in  1  pipeline writeback valid; no backpressure
- wb_a  in  5  pipeline writeback register
- wb_d  in  32  pipeline writeback data
- lu_issue  in  1  long-unit op issued this cycle
- lu_issue_a  in  5  destination of the issued op
- lu_valid  in  1  long-unit result valid
- lu_a  in  5  result destination
- lu_d  in  32  result data
- lu_ready  out  1  FIFO can accept a result (= not full)
- chk_a1, chk_a2  in  5  decode-stage source registers
- chk_a3  in  5  decode-stage destination register
- chk_we  in  1  decode-stage instruction writes chk_a3
- stall  out  1  decode must hold (combinational)
- rf_we  out  1  RF write enable
- rf_a  out  5  RF write address
- rf_wd  out  32  RF write data
- err  out  1  sticky protocol error

## Operation
- **Port ownership:**
  - A pipeline writeback is effective when wb_we=1 and wb_a≠0. It always owns the port: rf_we=1, rf_a=wb_a, rf_wd=wb_d.
  - Otherwise, if the FIFO is non-empty, the head drains: rf_we=1, rf_a/rf_wd = head, and the head pops at posedge.
  - Otherwise rf_we=0.
  - The outputs are a combinational mux.
- **FIFO:**
  - Pushes on lu_valid & lu_ready at posedge.
  - Entries whose lu_a=0 are pushed but drained with rf_we=0; they still pop, one cycle.
  - Push and pop in the same cycle are legal when full: count stays, but lu_ready is still 0 because it depends only on the registered count.
  - Pointers wrap modulo DEPTH.
- **Scoreboard:**
  - 32 busy bits; bit 0 is constant 0.
  - lu_issue with lu_issue_a≠0 sets busy[lu_issue_a].
  - A pop of an entry with address a clears busy[a].
  - If a set and a clear hit the same register in one cycle, set wins.
  - lu_issue to a register already busy and not being cleared that cycle sets err.
  - lu_valid for a register not busy sets err; the data is still buffered.
- **stall:** asserts when any of the following holds:
  - busy[chk_a1] or busy[chk_a2] (RAW);
  - chk_we & busy[chk_a3] (WAW);
  - the starvation flag is set.
- **Starvation:**
  - The counter increments each cycle the FIFO is non-empty and the head is blocked by an effective writeback.
  - It clears on any pop or when the FIFO is empty.
  - The flag is set when the counter reaches STARVE_MAX and cleared by the next pop.
  - The counter saturates.

## Timing
- Reset values: FIFO empty, all busy=0, counter=0, starve flag=0, err=0. Therefore lu_ready=1, rf_we=0 unless wb_we, and stall=0.
- Result latency: a result accepted at edge N is written to the RF in cycle N+1 at the earliest. There is no same-cycle bypass into the RF.
- A busy bit is set at the edge after lu_issue, so the dependent check sees it from the next cycle. Decode must not rely on same-cycle issue visibility.
- The busy clear takes effect at the pop edge. Since the RF writes on negedge in the pop cycle, a dependent instruction released in the following cycle reads the new value.
- Reset mid-operation drops FIFO contents and busy bits. The long unit is reset by the same rst.

## Structure
- Shared package (cpu_pkg): REG_W=5, DATA_W=32, NUM_REGS=32, and the FIFO entry struct {addr, data}.
- One sub-module, sync_fifo (DEPTH × entry, registered count, full/empty). Scoreboard, arbitration and starvation logic live in rf_wb_sched.
- Roughly 200 lines of RTL.

## Test plan
- **Basic drain:** issue to r5, then the result r5=0x1234 with wb_we=0.
  - Expect rf_we=1, rf_a=5, rf_wd=0x1234 the next cycle.
  - busy[5] clears, and stall on chk_a1=5 drops after the pop.
- **Priority:** FIFO holds r3 while wb_we=1, wb_a=7 for 2 cycles.
  - Expect r7 written both cycles.
  - r3 is written in the first cycle with wb_we=0.
- **Starvation (STARVE_MAX=4):** FIFO non-empty with wb_we=1 every cycle.
  - stall=1 from the 5th blocked cycle.
  - Drop wb_we: the pop occurs and stall clears the next cycle.
- **Full FIFO:** two results pushed while blocked.
  - lu_ready=0 with count 2.
  - A third lu_valid is held, not lost, and is accepted after a pop.
- **r0 and errors:** issue to r0 → no busy bit and no stall. Issue to r9 twice → err=1, sticky until rst.
- **Async reset mid-drain:** assert rst → rf_we=0 (unless wb_we) and lu_ready=1 immediately, without a clock.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared register-file types: widths and the long-unit result FIFO entry.
// Imported by the write-port scheduler and its result FIFO.
package cpu_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO of result entries; head visible combinationally, one-cycle push-to-pop.
// No internal backpressure: the caller must gate push with !full (push+pop when full keeps count).
module sync_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  fifo_entry_t push_dat,
  input  logic        pop,
  output fifo_entry_t head,
  output logic        full,
  output logic        empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t   mem_q [DEPTH];
  fifo_entry_t   mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == (PW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
endmodule

// File: rtl/rf_wb_sched.sv
// RF write-port scheduler: pipeline writeback wins, long-unit results drain from a FIFO when idle.
// Results reach the RF one cycle after acceptance at the earliest; lu_ready = FIFO not full; stall is combinational.
module rf_wb_sched
  import cpu_pkg::*;
#(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_a,
  input  logic [DATA_W-1:0] wb_d,
  input  logic              lu_issue,
  input  logic [REG_W-1:0]  lu_issue_a,
  input  logic              lu_valid,
  input  logic [REG_W-1:0]  lu_a,
  input  logic [DATA_W-1:0] lu_d,
  output logic              lu_ready,
  input  logic [REG_W-1:0]  chk_a1,
  input  logic [REG_W-1:0]  chk_a2,
  input  logic [REG_W-1:0]  chk_a3,
  input  logic              chk_we,
  output logic              stall,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_a,
  output logic [DATA_W-1:0] rf_wd,
  output logic              err
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  fifo_entry_t         head, push_dat;
  logic                full, empty, push, pop, wb_eff;
  logic [NUM_REGS-1:0] busy_q, busy_d, set_mask, clr_mask;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                starve_q, starve_d, err_q, err_d;

  sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  always_comb begin
    wb_eff   = wb_we && (wb_a != '0);
    pop      = !empty && !wb_eff;
    push     = lu_valid && !full;
    push_dat = '{addr: lu_a, data: lu_d};

    // r0 entries still pop, but never touch the RF
    rf_we = wb_eff || (pop && (head.addr != '0));
    rf_a  = wb_eff ? wb_a : head.addr;
    rf_wd = wb_eff ? wb_d : head.data;

    set_mask = '0;
    if (lu_issue && (lu_issue_a != '0)) set_mask[lu_issue_a] = 1'b1;
    clr_mask = '0;
    if (pop) clr_mask[head.addr] = 1'b1;
    busy_d    = (busy_q & ~clr_mask) | set_mask;
    busy_d[0] = 1'b0;

    err_d = err_q;
    if (lu_issue && (lu_issue_a != '0) && busy_q[lu_issue_a] && !clr_mask[lu_issue_a]) err_d = 1'b1;
    if (lu_valid && !busy_q[lu_a]) err_d = 1'b1;

    // non-empty and not popping means the head lost to a writeback
    if (pop || empty)                   cnt_d = '0;
    else if (cnt_q != CW'(STARVE_MAX)) cnt_d = cnt_q + CW'(1);
    else                                cnt_d = cnt_q;
    starve_d = !pop && (starve_q || (cnt_d == CW'(STARVE_MAX)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= '0;
      cnt_q    <= '0;
      starve_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign lu_ready = !full;
  assign err      = err_q;
  assign stall    = busy_q[chk_a1] || busy_q[chk_a2] || (chk_we && busy_q[chk_a3]) || starve_q;
endmodule

// File: tb/tb_rf_wb_sched.sv
// Bench for rf_wb_sched: queue/array reference model checked every cycle, directed scenarios plus random traffic.
module tb_rf_wb_sched;
  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, lu_issue, lu_valid, chk_we;
  logic [4:0]  wb_a, lu_issue_a, lu_a, chk_a1, chk_a2, chk_a3;
  logic [31:0] wb_d, lu_d;
  logic        lu_ready, stall, rf_we, err;
  logic [4:0]  rf_a;
  logic [31:0] rf_wd;

  int checks   = 0;
  int failures = 0;

  logic [4:0]  qa[$];
  logic [31:0] qd[$];
  bit          m_busy[32];
  int          m_cnt;
  bit          m_starve, m_err;

  rf_wb_sched #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_a(wb_a), .wb_d(wb_d),
    .lu_issue(lu_issue), .lu_issue_a(lu_issue_a),
    .lu_valid(lu_valid), .lu_a(lu_a), .lu_d(lu_d), .lu_ready(lu_ready),
    .chk_a1(chk_a1), .chk_a2(chk_a2), .chk_a3(chk_a3), .chk_we(chk_we),
    .stall(stall), .rf_we(rf_we), .rf_a(rf_a), .rf_wd(rf_wd), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qd.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_cnt    = 0;
    m_starve = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic check_model();
    bit          wbe, ewe;
    logic [4:0]  ea;
    logic [31:0] ed;
    if (rst) model_reset();
    wbe = wb_we && (wb_a != 0);
    ewe = 1'b0; ea = '0; ed = '0;
    if (wbe) begin
      ewe = 1'b1; ea = wb_a; ed = wb_d;
    end else if (qa.size() > 0) begin
      ewe = (qa[0] != 0); ea = qa[0]; ed = qd[0];
    end
    chk("m_rf_we", rf_we, ewe);
    if (ewe) begin
      chk("m_rf_a", rf_a, ea);
      chk("m_rf_wd", rf_wd, ed);
    end
    chk("m_lu_ready", lu_ready, qa.size() < DEPTH);
    chk("m_stall", stall, m_busy[chk_a1] || m_busy[chk_a2] || (chk_we && m_busy[chk_a3]) || m_starve);
    chk("m_err", err, m_err);
  endtask

  task automatic model_update();
    bit         wbe, pop, push, was_empty;
    logic [4:0] pa;
    wbe       = wb_we && (wb_a != 0);
    was_empty = (qa.size() == 0);
    pop       = !was_empty && !wbe;
    pa        = pop ? qa[0] : 5'd0;
    push      = lu_valid && (qa.size() < DEPTH);
    if (lu_issue && lu_issue_a != 0 && m_busy[lu_issue_a] && !(pop && pa == lu_issue_a)) m_err = 1'b1;
    if (lu_valid && !m_busy[lu_a]) m_err = 1'b1;
    if (pop) begin
      m_busy[pa] = 1'b0;
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    if (lu_issue && lu_issue_a != 0) m_busy[lu_issue_a] = 1'b1;
    if (push) begin
      qa.push_back(lu_a);
      qd.push_back(lu_d);
    end
    if (pop || was_empty) m_cnt = 0;
    else if (m_cnt < STARVE_MAX) m_cnt++;
    m_starve = pop ? 1'b0 : (m_starve || m_cnt == STARVE_MAX);
  endtask

  task automatic zero_in();
    wb_we = 0; wb_a = 0; wb_d = 0;
    lu_issue = 0; lu_issue_a = 0; lu_valid = 0; lu_a = 0; lu_d = 0;
    chk_a1 = 0; chk_a2 = 0; chk_a3 = 0; chk_we = 0;
  endtask

  task automatic begin_cyc();
    @(negedge clk);
    zero_in();
  endtask

  task automatic cmp();
    #2;
    check_model();
  endtask

  task automatic end_cyc();
    @(posedge clk);
    if (rst) model_reset();
    else model_update();
  endtask

  task automatic issue(input logic [4:0] a);
    begin_cyc(); lu_issue = 1; lu_issue_a = a; cmp(); end_cyc();
  endtask

  task automatic idle();
    begin_cyc(); cmp(); end_cyc();
  endtask

  initial begin
    rst = 1'b1;
    zero_in();
    model_reset();

    // reset state, writeback still passes through
    begin_cyc(); wb_we = 1; wb_a = 2; wb_d = 32'h22; cmp();
    chk("rst_rf_we_wb", rf_we, 1); chk("rst_rf_a_wb", rf_a, 2);
    chk("rst_lu_ready", lu_ready, 1); chk("rst_stall", stall, 0); chk("rst_err", err, 0);
    end_cyc();
    begin_cyc(); rst = 0; cmp(); chk("rst_rf_we", rf_we, 0); end_cyc();

    // basic drain
    issue(5);
    begin_cyc(); lu_valid = 1; lu_a = 5; lu_d = 32'h1234; chk_a1 = 5; cmp();
    chk("drain_raw_stall", stall, 1); end_cyc();
    begin_cyc(); chk_a1 = 5; cmp();
    chk("drain_rf_we", rf_we, 1); chk("drain_rf_a", rf_a, 5); chk("drain_rf_wd", rf_wd, 32'h1234);
    chk("drain_stall_pop_cycle", stall, 1); end_cyc();
    begin_cyc(); chk_a1 = 5; cmp();
    chk("drain_stall_drop", stall, 0); chk("drain_idle_we", rf_we, 0); end_cyc();

    // writeback priority over FIFO head
    issue(3);
    begin_cyc(); lu_valid = 1; lu_a = 3; lu_d = 32'hAA; cmp(); end_cyc();
    for (int i = 0; i < 2; i++) begin
      begin_cyc(); wb_we = 1; wb_a = 7; wb_d = 32'h70 + i; cmp();
      chk("prio_wb_a", rf_a, 7); chk("prio_wb_d", rf_wd, 32'h70 + i); end_cyc();
    end
    begin_cyc(); cmp();
    chk("prio_head_we", rf_we, 1); chk("prio_head_a", rf_a, 3); chk("prio_head_d", rf_wd, 32'hAA); end_cyc();
    idle();

    // starvation
    issue(4);
    begin_cyc(); lu_valid = 1; lu_a = 4; lu_d = 32'h44; cmp(); end_cyc();
    for (int i = 1; i <= 5; i++) begin
      begin_cyc(); wb_we = 1; wb_a = 8; wb_d = i; cmp();
      chk("starve_stall", stall, (i == 5)); end_cyc();
    end
    begin_cyc(); cmp();
    chk("starve_pop_stall", stall, 1); chk("starve_pop_a", rf_a, 4); end_cyc();
    begin_cyc(); cmp(); chk("starve_clear", stall, 0); end_cyc();

    // full FIFO and held result
    issue(10); issue(11); issue(12);
    begin_cyc(); wb_we = 1; wb_a = 1; lu_valid = 1; lu_a = 10; lu_d = 32'hA0; cmp(); end_cyc();
    begin_cyc(); wb_we = 1; wb_a = 1; lu_valid = 1; lu_a = 11; lu_d = 32'hB0; cmp(); end_cyc();
    begin_cyc(); wb_we = 1; wb_a = 1; lu_valid = 1; lu_a = 12; lu_d = 32'hC0; cmp();
    chk("full_ready", lu_ready, 0); end_cyc();
    begin_cyc(); lu_valid = 1; lu_a = 12; lu_d = 32'hC0; cmp();
    chk("full_ready_pop", lu_ready, 0); chk("full_pop_a", rf_a, 10); end_cyc();
    begin_cyc(); lu_valid = 1; lu_a = 12; lu_d = 32'hC0; cmp();
    chk("full_ready_again", lu_ready, 1); chk("full_pop2_a", rf_a, 11); end_cyc();
    begin_cyc(); cmp(); chk("full_held_a", rf_a, 12); chk("full_held_d", rf_wd, 32'hC0); end_cyc();
    begin_cyc(); cmp(); chk("full_empty_we", rf_we, 0); chk("full_no_err", err, 0); end_cyc();

    // r0 and duplicate issue
    issue(0);
    begin_cyc(); chk_we = 1; cmp(); chk("r0_no_stall", stall, 0); end_cyc();
    issue(9); issue(9);
    begin_cyc(); cmp(); chk("dup_err", err, 1); end_cyc();
    idle(); idle();
    begin_cyc(); cmp(); chk("err_sticky", err, 1); end_cyc();
    begin_cyc(); rst = 1; chk_a1 = 9; cmp();
    chk("err_rst", err, 0); chk("busy_rst", stall, 0); end_cyc();
    begin_cyc(); rst = 0; cmp(); end_cyc();

    // async reset mid-drain with a full FIFO
    issue(6); issue(13);
    begin_cyc(); wb_we = 1; wb_a = 1; lu_valid = 1; lu_a = 6; lu_d = 32'h66; cmp(); end_cyc();
    begin_cyc(); wb_we = 1; wb_a = 1; lu_valid = 1; lu_a = 13; lu_d = 32'hD0; cmp(); end_cyc();
    begin_cyc(); cmp();
    chk("ar_pre_ready", lu_ready, 0); chk("ar_pre_a", rf_a, 6);
    #1 rst = 1;
    #1;
    chk("ar_rf_we", rf_we, 0); chk("ar_lu_ready", lu_ready, 1);
    end_cyc();
    begin_cyc(); rst = 0; cmp(); end_cyc();

    // random traffic, phases of heavy and light writeback load
    for (int n = 0; n < 2400; n++) begin
      int         heavy;
      logic [4:0] a;
      logic [4:0] busy_list[$];
      begin_cyc();
      rst   = (n % 400 == 399);
      heavy = ((n / 150) % 2);
      wb_we = heavy ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      wb_a  = 5'($urandom_range(0, 15));
      wb_d  = $urandom;
      a = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 4 && (!m_busy[a] || $urandom_range(0, 7) == 0)) begin
        lu_issue = 1; lu_issue_a = a;
      end
      for (int r = 1; r < 32; r++) if (m_busy[r]) busy_list.push_back(5'(r));
      if (busy_list.size() > 0 && $urandom_range(0, 9) < 4) begin
        lu_valid = 1; lu_a = busy_list[$urandom_range(0, busy_list.size() - 1)]; lu_d = $urandom;
      end else if ($urandom_range(0, 39) == 0) begin
        lu_valid = 1; lu_a = 5'($urandom_range(0, 7)); lu_d = $urandom;
      end
      chk_a1 = 5'($urandom_range(0, 7));
      chk_a2 = 5'($urandom_range(0, 7));
      chk_a3 = 5'($urandom_range(0, 7));
      chk_we = 1'($urandom_range(0, 1));
      cmp();
      end_cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
